macro_weight_loader: RTL and testbench

Write-side controller for the 3x3 CIM macro array. It accepts a valid/ready stream of 288-bit weight rows (4b x 8 x 9 macros) and drives the array's standard-write port (STDW, STD_A, weight_in) for rows 0..63 in order. It can optionally read each row back through STDR/weight_out and compare it against the written data. It sits between the weight DMA/buffer and the macro array, and holds the array out of compute mode while loading.

---
 rtl/cim_pkg.sv | 18 +
 rtl/macro_weight_loader_if.sv | 23 ++
 rtl/macro_weight_loader.sv | 129 ++++++++++++
 tb/tb_macro_weight_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared constants and state encoding for the CIM macro array write-side logic.
// Geometry: 9 macros x 32b weight slices, 64 rows deep.
package cim_pkg;

   localparam int CIM_ROWS   = 64;
   localparam int CIM_ADDR_W = 6;
   localparam int MACRO_WW   = 32;
   localparam int ARRAY_WW   = 288;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      READ,
      DONE
   } loader_state_t;

endpackage

// File: rtl/macro_weight_loader_if.sv
// Valid/ready weight-row stream between the weight DMA/buffer (master)
// and the macro weight loader (slave).
interface macro_weight_loader_if import cim_pkg::*; #(
   parameter int WORD_W = ARRAY_WW
) ();

   logic              w_valid;
   logic [WORD_W-1:0] w_data;
   logic              w_ready;

   modport master (
      output w_valid,
      output w_data,
      input  w_ready
   );

   modport slave (
      input  w_valid,
      input  w_data,
      output w_ready
   );

endinterface

// File: rtl/macro_weight_loader.sv
// Streams 64 weight rows into the CIM macro array through its standard-write
// port, optionally reading each row back and flagging the first mismatch.
module macro_weight_loader import cim_pkg::*; #(
   parameter int ROWS   = CIM_ROWS,
   parameter int ADDR_W = CIM_ADDR_W,
   parameter int WORD_W = ARRAY_WW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              verify_en,
   macro_weight_loader_if.slave ws,
   output logic              STDW,
   output logic              STDR,
   output logic [ADDR_W-1:0] STD_A,
   output logic [WORD_W-1:0] weight_in,
   input  logic [WORD_W-1:0] weight_out,
   output logic              CIM_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr
);

   localparam int                NMAC      = WORD_W / MACRO_WW;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

   loader_state_t     state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [WORD_W-1:0] wbuf_reg;
   logic              vmode_reg;
   logic              stdw_reg, stdr_reg, busy_reg, cim_en_reg, done_reg;
   logic              err_reg;
   logic [ADDR_W-1:0] err_addr_reg;
   logic              last_row;
   logic              mismatch;
   logic [NMAC-1:0]   macro_mis;

   // Readback compare is done per macro slice, then reduced.
   genvar gi;
   generate
      for (gi = 0; gi < NMAC; gi++) begin : g_mac
         assign macro_mis[gi] = weight_out[gi*MACRO_WW +: MACRO_WW] != wbuf_reg[gi*MACRO_WW +: MACRO_WW];
      end
   endgenerate

   assign mismatch = |macro_mis;
   assign last_row = (addr_reg == LAST_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    if (ws.w_valid) state_next = WRITE;
         WRITE:   if (vmode_reg) state_next = READ;
                  else           state_next = last_row ? DONE : LOAD;
         READ:    state_next = last_row ? DONE : LOAD;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes and status are registered from the next state so every array-facing
   // output comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg     <= '0;
         wbuf_reg     <= '0;
         vmode_reg    <= 1'b0;
         stdw_reg     <= 1'b0;
         stdr_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         cim_en_reg   <= 1'b1;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         err_addr_reg <= '0;
      end else begin
         stdw_reg   <= (state_next == WRITE);
         stdr_reg   <= (state_next == READ);
         busy_reg   <= (state_next != IDLE);
         cim_en_reg <= (state_next == IDLE);
         done_reg   <= (state_next == DONE);

         if (state_next == IDLE) begin
            addr_reg <= '0;
         end else if (state_next == LOAD && (state_reg == WRITE || state_reg == READ)) begin
            addr_reg <= addr_reg + 1'b1;
         end

         if (state_reg == IDLE && start) begin
            vmode_reg    <= verify_en;
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
         end

         if (state_reg == LOAD && ws.w_valid) begin
            wbuf_reg <= ws.w_data;
         end

         // Only the first mismatching row is remembered; err stays set until the next start.
         if (state_reg == READ && mismatch) begin
            err_reg <= 1'b1;
            if (!err_reg) begin
               err_addr_reg <= addr_reg;
            end
         end
      end
   end

   assign ws.w_ready = (state_reg == LOAD);
   assign STDW       = stdw_reg;
   assign STDR       = stdr_reg;
   assign STD_A      = addr_reg;
   assign weight_in  = wbuf_reg;
   assign CIM_en     = cim_en_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign err        = err_reg;
   assign err_addr   = err_addr_reg;

endmodule

// File: tb/tb_macro_weight_loader.sv
// Randomised bench for macro_weight_loader: a schedule-level model of each load
// predicts every output on every cycle; a behavioural array echoes writes.
module tb_macro_weight_loader;
   import cim_pkg::*;

   localparam int N     = CIM_ROWS;
   localparam int W     = ARRAY_WW;
   localparam int AW    = CIM_ADDR_W;
   localparam int BIG   = 1 << 28;
   localparam int NEVER = -2000000000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          verify_en = 1'b0;
   logic          stdw, stdr, cim_en, busy, done, err;
   logic [AW-1:0] std_a, err_addr;
   logic [W-1:0]  weight_in, weight_out;

   macro_weight_loader_if wif ();

   macro_weight_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .verify_en  (verify_en),
      .ws         (wif),
      .STDW       (stdw),
      .STDR       (stdr),
      .STD_A      (std_a),
      .weight_in  (weight_in),
      .weight_out (weight_out),
      .CIM_en     (cim_en),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_addr   (err_addr)
   );

   always #5 clk = ~clk;

   int gcyc = 0;
   always @(posedge clk) gcyc <= gcyc + 1;

   // Behavioural macro array: stores writes, returns (optionally corrupted) rows on read.
   logic [W-1:0] mem   [N];
   logic [W-1:0] cmask [N];
   always @(posedge clk) if (stdw) mem[std_a] <= weight_in;
   assign weight_out = stdr ? (mem[std_a] ^ cmask[std_a]) : '0;

   // Plan of the current load, in cycles relative to the start cycle (rc = 0).
   logic [W-1:0]  rdata [N];
   int            nst   [N];
   int            lc    [N];
   int            wc    [N];
   int            rcyc  [N];
   bit            bad   [N];
   bit            vm = 1'b0;
   int            dcyc = 0;
   int            t0 = BIG;
   int            spulse_a = NEVER, spulse_b = NEVER;
   int            run_no = 0;
   logic          prev_err = 1'b0, fin_err = 1'b0;
   logic [AW-1:0] prev_ea = '0, fin_ea = '0;
   logic [W-1:0]  prev_win = '0, fin_win = '0;
   int            done_gcyc = -1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, gcyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", name, gcyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic plan_run(input int t_start);
      int c;
      prev_err = fin_err;
      prev_ea  = fin_ea;
      prev_win = fin_win;
      fin_err  = 1'b0;
      fin_ea   = '0;
      c = 1;
      for (int k = 0; k < N; k++) begin
         lc[k]   = c;
         wc[k]   = c + nst[k] + 1;
         rcyc[k] = vm ? wc[k] + 1 : -1;
         c       = wc[k] + (vm ? 2 : 1);
         bad[k]  = vm && (cmask[k] != '0);
         if (bad[k] && !fin_err) begin
            fin_err = 1'b1;
            fin_ea  = AW'(k);
         end
      end
      dcyc     = c;
      fin_win  = rdata[N-1];
      spulse_a = NEVER;
      spulse_b = NEVER;
      t0       = t_start;
      run_no++;
      $display("run %0d: verify=%0d start_cycle=%0d expected_done=+%0d expected_err=%0d err_addr=%0d",
               run_no, vm, t_start, dcyc, fin_err, fin_ea);
   endtask

   task automatic drive_cycle();
      int           rc;
      logic         v;
      logic [W-1:0] d;
      rc = gcyc - t0;
      v  = 1'($urandom_range(0, 1));
      d  = rand_word();
      if (rc >= 1 && rc < dcyc) begin
         for (int k = 0; k < N; k++) begin
            if (rc >= lc[k] && rc <= lc[k] + nst[k]) begin
               v = (rc == lc[k] + nst[k]);
               if (v) d = rdata[k];
            end
         end
      end
      wif.w_valid = v;
      wif.w_data  = d;
      start       = (rc == 0) || (rc == spulse_a) || (rc == spulse_b);
      verify_en   = (rc == 0) ? vm : 1'($urandom_range(0, 1));
   endtask

   always @(posedge clk) begin
      #2;
      drive_cycle();
   end

   task automatic compare_cycle();
      int            rc, k;
      logic          e_stdw, e_stdr, e_wr, e_busy, e_done, e_en, e_err;
      logic [AW-1:0] e_a, e_ea;
      logic [W-1:0]  e_win;
      rc = gcyc - t0;
      e_stdw = 1'b0; e_stdr = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_en = 1'b1; e_a = '0; e_err = 1'b0; e_ea = '0; e_win = '0;
      if (!rst) begin
         if (rc < 1) begin
            e_err = prev_err; e_ea = prev_ea; e_win = prev_win;
         end else if (rc > dcyc) begin
            e_err = fin_err; e_ea = fin_ea; e_win = fin_win;
         end else begin
            e_busy = 1'b1;
            e_en   = 1'b0;
            for (int j = 0; j < N; j++) begin
               if (bad[j] && rcyc[j] < rc && !e_err) begin
                  e_err = 1'b1;
                  e_ea  = AW'(j);
               end
            end
            if (rc == dcyc) begin
               e_done = 1'b1;
               e_a    = AW'(N - 1);
               e_win  = rdata[N-1];
            end else begin
               k = 0;
               for (int j = 0; j < N; j++) if (lc[j] <= rc) k = j;
               e_a    = AW'(k);
               e_wr   = (rc <= lc[k] + nst[k]);
               e_stdw = (rc == wc[k]);
               e_stdr = vm && (rc == rcyc[k]);
               if (rc >= wc[k]) e_win = rdata[k];
               else             e_win = (k == 0) ? prev_win : rdata[k-1];
            end
         end
      end
      chk("STDW", W'(stdw), W'(e_stdw));
      chk("STDR", W'(stdr), W'(e_stdr));
      chk("STD_A", W'(std_a), W'(e_a));
      chk("weight_in", weight_in, e_win);
      chk("w_ready", W'(wif.w_ready), W'(e_wr));
      chk("busy", W'(busy), W'(e_busy));
      chk("CIM_en", W'(cim_en), W'(e_en));
      chk("done", W'(done), W'(e_done));
      chk("err", W'(err), W'(e_err));
      chk("err_addr", W'(err_addr), W'(e_ea));
   endtask

   always @(negedge clk) begin
      #1;
      compare_cycle();
   end

   always @(negedge clk) if (done) done_gcyc <= gcyc;

   task automatic wait_rel(input int target);
      do @(negedge clk); while (gcyc - t0 < target);
      #3;
   endtask

   task automatic fill_random(input bit v, input int max_stall);
      vm = v;
      for (int k = 0; k < N; k++) begin
         rdata[k] = rand_word();
         nst[k]   = $urandom_range(0, max_stall);
         cmask[k] = '0;
      end
   endtask

   initial begin
      logic [7:0] kb;
      int         r1, r2;
      wif.w_valid = 1'b0;
      wif.w_data  = '0;
      for (int k = 0; k < N; k++) cmask[k] = '0;

      // Reset state
      @(negedge clk); #3;
      chk("rst_STDW", W'(stdw), W'(1'b0));
      chk("rst_busy", W'(busy), W'(1'b0));
      chk("rst_CIM_en", W'(cim_en), W'(1'b1));
      chk("rst_weight_in", weight_in, '0);
      @(negedge clk); #3;
      rst = 1'b0;

      // A: plain load, nibble pattern rows
      @(negedge clk); #3;
      vm = 1'b0;
      for (int k = 0; k < N; k++) begin
         kb       = 8'(k);
         rdata[k] = {36{kb}};
         nst[k]   = 0;
      end
      plan_run(gcyc + 1);
      wait_rel(2);
      chk("A_row0_STDW", W'(stdw), W'(1'b1));
      wait_rel(dcyc + 2);
      chk_int("A_done_cycle", done_gcyc - t0, 129);

      // B: verified load with a clean array
      @(negedge clk); #3;
      fill_random(1'b1, 0);
      plan_run(gcyc + 1);
      wait_rel(dcyc + 2);
      chk_int("B_done_cycle", done_gcyc - t0, 193);
      chk("B_err", W'(err), W'(1'b0));

      // C: verified load, rows 17 and 40 corrupted on readback
      @(negedge clk); #3;
      fill_random(1'b1, 0);
      cmask[17] = '0; cmask[17][5] = 1'b1;
      cmask[40] = '0; cmask[40][$urandom_range(0, W - 1)] = 1'b1;
      plan_run(gcyc + 1);
      wait_rel(54);
      chk("C_err_during_read17", W'(err), W'(1'b0));
      wait_rel(55);
      chk("C_err_after_read17", W'(err), W'(1'b1));
      chk("C_err_addr_after_read17", W'(err_addr), W'(17));
      wait_rel(dcyc + 2);
      chk("C_err_final", W'(err), W'(1'b1));
      chk("C_err_addr_final", W'(err_addr), W'(17));

      // D: stalls before rows 0 and 63, stray starts mid-load and in DONE
      @(negedge clk); #3;
      fill_random(1'b0, 0);
      nst[0]  = 3;
      nst[63] = 3;
      plan_run(gcyc + 1);
      spulse_a = 50;
      spulse_b = dcyc;
      wait_rel(1);
      chk("D_err_cleared", W'(err), W'(1'b0));
      wait_rel(4);
      chk("D_stall_w_ready", W'(wif.w_ready), W'(1'b1));
      wait_rel(5);
      chk("D_row0_STDW", W'(stdw), W'(1'b1));
      wait_rel(135);
      chk_int("D_done_cycle", done_gcyc - t0, 135);

      // E: start in the first IDLE cycle after D, random stalls and corruption
      fill_random(1'b1, 2);
      r1 = $urandom_range(0, N - 1);
      r2 = $urandom_range(0, N - 1);
      cmask[r1][$urandom_range(0, W - 1)] = 1'b1;
      cmask[r2][$urandom_range(0, W - 1)] = 1'b1;
      plan_run(gcyc + 1);
      spulse_a = $urandom_range(1, dcyc);
      wait_rel(dcyc + 2);

      // F: reset during row 30 WRITE
      @(negedge clk); #3;
      fill_random(1'($urandom_range(0, 1)), 1);
      plan_run(gcyc + 1);
      wait_rel(wc[30]);
      chk("F_STDW_before_rst", W'(stdw), W'(1'b1));
      t0 = BIG; fin_err = 1'b0; fin_ea = '0; fin_win = '0;
      prev_err = 1'b0; prev_ea = '0; prev_win = '0;
      rst = 1'b1;
      #1;
      chk("F_rst_STDW", W'(stdw), W'(1'b0));
      chk("F_rst_busy", W'(busy), W'(1'b0));
      chk("F_rst_CIM_en", W'(cim_en), W'(1'b1));
      chk("F_rst_STD_A", W'(std_a), W'(0));
      repeat (2) @(negedge clk);
      #3;
      rst = 1'b0;

      // G: restart after the abandoned load
      @(negedge clk); #3;
      fill_random(1'b1, 1);
      plan_run(gcyc + 1);
      wait_rel(wc[0]);
      chk("G_first_STD_A", W'(std_a), W'(0));
      chk("G_first_STDW", W'(stdw), W'(1'b1));
      wait_rel(dcyc + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
